// File: rtl/periph_reg_target.sv
// periph_reg_target: register-file target with grant wait states and a fixed-latency response pipeline
// Ports: clk_i/rst_ni clock and sync active-low reset; req_i/add_i/wen_i/wdata_i/be_i/id_i request side;
//        gnt_o request accepted this cycle; r_valid_o/r_rdata_o/r_opc_o/r_id_o response side.
module periph_reg_target #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = 9,
  parameter int NB_REGS = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int RESP_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hCA1B_0001
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic [ADDR_WIDTH-1:0]   add_i,
  input  logic                    wen_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ID_WIDTH-1:0]     id_i,
  output logic                    gnt_o,
  output logic                    r_valid_o,
  output logic [DATA_WIDTH-1:0]   r_rdata_o,
  output logic                    r_opc_o,
  output logic [ID_WIDTH-1:0]     r_id_o
);
  localparam int IW = (NB_REGS > 1) ? $clog2(NB_REGS) : 1;
  localparam int EW = 2 + ID_WIDTH + DATA_WIDTH;
  typedef enum logic {IDLE, WAIT} state_e;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [NB_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NB_REGS];
  logic [EW-1:0] pipe_q [RESP_LATENCY];
  logic [EW-1:0] pipe_d [RESP_LATENCY];
  logic [7:0] idx;
  logic err, acc;
  logic [DATA_WIDTH-1:0] rd_val;
  logic unused_addr;
  assign idx = add_i[9:2];
  assign unused_addr = ^add_i[ADDR_WIDTH-1:10];
  assign err = (add_i[1:0] != 2'b00) | ({1'b0, idx} >= 9'(NB_REGS)) | (!wen_i && idx == 8'd0);
  assign rd_val = (idx == 8'd0) ? ID_VALUE : regs_q[idx[IW-1:0]];
  assign acc = req_i & gnt_o;
  // Grant FSM: with no wait states the grant is a pass-through of req_i.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    gnt_o = 1'b0;
    if (rst_ni) begin
      if (WAIT_CYCLES == 0) gnt_o = req_i;
      else if (state_q == IDLE) begin
        if (req_i) begin
          state_d = WAIT;
          cnt_d = 4'(WAIT_CYCLES - 1);
        end
      end else if (!req_i) begin
        state_d = IDLE;
        cnt_d = 4'd0;
      end else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        gnt_o = 1'b1;
        state_d = IDLE;
      end
    end
  end
  // Reads sample regs_q before the same-edge write lands; payload is zero unless valid.
  always_comb begin
    regs_d = regs_q;
    if (acc && !err && !wen_i)
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (be_i[b]) regs_d[idx[IW-1:0]][8*b +: 8] = wdata_i[8*b +: 8];
    pipe_d[0] = acc ? {1'b1, err, id_i, (!err && wen_i) ? rd_val : {DATA_WIDTH{1'b0}}} : '0;
    for (int i = 1; i < RESP_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      for (int i = 0; i < NB_REGS; i++) regs_q[i] <= '0;
      for (int i = 0; i < RESP_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      regs_q <= regs_d;
      pipe_q <= pipe_d;
    end
  end
  assign {r_valid_o, r_opc_o, r_id_o, r_rdata_o} = pipe_q[RESP_LATENCY-1];
endmodule

// File: tb/tb_periph_reg_target.sv
// tb_periph_reg_target: directed checks on three configurations (W0/L1, W3/L4, W0/L4)
module tb_periph_reg_target;
  logic clk = 1'b0;
  logic rst_n;
  logic req [3];
  logic wen [3];
  logic [31:0] add [3];
  logic [31:0] wdat [3];
  logic [3:0] be [3];
  logic [8:0] id [3];
  logic gnt [3];
  logic rv [3];
  logic ro [3];
  logic [31:0] rdat [3];
  logic [8:0] ri [3];
  int tests = 0;
  int fails = 0;
  int stepn = 0;

  always #5 clk = ~clk;

  periph_reg_target #(.WAIT_CYCLES(0), .RESP_LATENCY(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .add_i(add[0]), .wen_i(wen[0]),
    .wdata_i(wdat[0]), .be_i(be[0]), .id_i(id[0]), .gnt_o(gnt[0]), .r_valid_o(rv[0]),
    .r_rdata_o(rdat[0]), .r_opc_o(ro[0]), .r_id_o(ri[0]));
  periph_reg_target #(.WAIT_CYCLES(3), .RESP_LATENCY(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .add_i(add[1]), .wen_i(wen[1]),
    .wdata_i(wdat[1]), .be_i(be[1]), .id_i(id[1]), .gnt_o(gnt[1]), .r_valid_o(rv[1]),
    .r_rdata_o(rdat[1]), .r_opc_o(ro[1]), .r_id_o(ri[1]));
  periph_reg_target #(.WAIT_CYCLES(0), .RESP_LATENCY(4)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .add_i(add[2]), .wen_i(wen[2]),
    .wdata_i(wdat[2]), .be_i(be[2]), .id_i(id[2]), .gnt_o(gnt[2]), .r_valid_o(rv[2]),
    .r_rdata_o(rdat[2]), .r_opc_o(ro[2]), .r_id_o(ri[2]));

  task automatic chk(input int u, input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL u%0d step%0d %s observed %0h expected %0h", u, stepn, tag, o, e);
    end
  endtask

  // Checks the response registered at the previous edge, drives a request, checks the grant, then clocks.
  task automatic step(input int u, input logic rq, input logic w, input logic [31:0] ad,
                      input logic [31:0] wd, input logic [3:0] b, input logic [8:0] iv,
                      input logic eg, input logic ev, input logic eo, input logic [31:0] er,
                      input logic [8:0] ei);
    chk(u, "r_valid", rv[u], ev);
    chk(u, "r_opc", ro[u], eo);
    chk(u, "r_rdata", rdat[u], er);
    chk(u, "r_id", ri[u], ei);
    req[u] = rq; wen[u] = w; add[u] = ad; wdat[u] = wd; be[u] = b; id[u] = iv;
    #1;
    chk(u, "gnt", gnt[u], eg);
    @(posedge clk); #1;
    stepn++;
  endtask

  task automatic do_rd(input int u, input logic [31:0] ad, input logic [8:0] iv, input logic eg,
                       input logic ev, input logic eo, input logic [31:0] er, input logic [8:0] ei);
    step(u, 1'b1, 1'b1, ad, 32'h0, 4'h0, iv, eg, ev, eo, er, ei);
  endtask

  task automatic do_wr(input int u, input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] b,
                       input logic [8:0] iv, input logic eg,
                       input logic ev, input logic eo, input logic [31:0] er, input logic [8:0] ei);
    step(u, 1'b1, 1'b0, ad, wd, b, iv, eg, ev, eo, er, ei);
  endtask

  task automatic do_idle(input int u, input logic ev, input logic eo, input logic [31:0] er,
                         input logic [8:0] ei);
    step(u, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 9'h0, 1'b0, ev, eo, er, ei);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; wen[i] = 1'b1; add[i] = '0; wdat[i] = '0; be[i] = '0; id[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    // Reset held with a request pending: no grant, outputs cleared.
    do_rd(0, 32'h08, 9'h001, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    // W0/L1 basic write/read, byte enables, errors.
    do_wr(0, 32'h08, 32'hDEADBEEF, 4'hF, 9'h004, 1, 0, 0, 0, 0);
    do_rd(0, 32'h08, 9'h010, 1, 1, 0, 0, 9'h004);
    do_wr(0, 32'h04, 32'h11223344, 4'hF, 9'h001, 1, 1, 0, 32'hDEADBEEF, 9'h010);
    do_wr(0, 32'h04, 32'hAABBCCDD, 4'h5, 9'h002, 1, 1, 0, 0, 9'h001);
    do_rd(0, 32'h04, 9'h003, 1, 1, 0, 0, 9'h002);
    do_rd(0, 32'h20, 9'h005, 1, 1, 0, 32'h11BB33DD, 9'h003);
    do_rd(0, 32'h05, 9'h006, 1, 1, 1, 0, 9'h005);
    do_wr(0, 32'h00, 32'hFFFFFFFF, 4'hF, 9'h007, 1, 1, 1, 0, 9'h006);
    do_wr(0, 32'h06, 32'hFFFFFFFF, 4'hF, 9'h008, 1, 1, 1, 0, 9'h007);
    do_rd(0, 32'h00, 9'h009, 1, 1, 1, 0, 9'h008);
    do_rd(0, 32'h04, 9'h00A, 1, 1, 0, 32'hCA1B0001, 9'h009);
    do_rd(0, 32'h1C, 9'h00B, 1, 1, 0, 32'h11BB33DD, 9'h00A);
    do_idle(0, 1, 0, 0, 9'h00B);
    do_idle(0, 0, 0, 0, 0);
    // W3/L4: held request granted on the fourth cycle, response four cycles later.
    do_rd(1, 32'h00, 9'h001, 0, 0, 0, 0, 0);
    do_rd(1, 32'h00, 9'h001, 0, 0, 0, 0, 0);
    do_rd(1, 32'h00, 9'h001, 0, 0, 0, 0, 0);
    do_rd(1, 32'h00, 9'h001, 1, 0, 0, 0, 0);
    do_idle(1, 0, 0, 0, 0);
    do_idle(1, 0, 0, 0, 0);
    do_idle(1, 0, 0, 0, 0);
    do_idle(1, 1, 0, 32'hCA1B0001, 9'h001);
    // Dropped write request: no grant, no side effect, next request restarts the wait.
    do_wr(1, 32'h08, 32'h12345678, 4'hF, 9'h002, 0, 0, 0, 0, 0);
    do_idle(1, 0, 0, 0, 0);
    do_rd(1, 32'h08, 9'h004, 0, 0, 0, 0, 0);
    do_rd(1, 32'h08, 9'h004, 0, 0, 0, 0, 0);
    do_rd(1, 32'h08, 9'h004, 0, 0, 0, 0, 0);
    do_rd(1, 32'h08, 9'h004, 1, 0, 0, 0, 0);
    do_idle(1, 0, 0, 0, 0);
    do_idle(1, 0, 0, 0, 0);
    do_idle(1, 0, 0, 0, 0);
    do_idle(1, 1, 0, 0, 9'h004);
    do_idle(1, 0, 0, 0, 0);
    // W0/L4: back-to-back transactions, in-order responses.
    do_wr(2, 32'h0C, 32'hCAFEF00D, 4'hF, 9'h100, 1, 0, 0, 0, 0);
    do_rd(2, 32'h0C, 9'h001, 1, 0, 0, 0, 0);
    do_rd(2, 32'h00, 9'h002, 1, 0, 0, 0, 0);
    do_rd(2, 32'h04, 9'h004, 1, 0, 0, 0, 0);
    do_rd(2, 32'h0C, 9'h008, 1, 1, 0, 0, 9'h100);
    do_idle(2, 1, 0, 32'hCAFEF00D, 9'h001);
    do_idle(2, 1, 0, 32'hCA1B0001, 9'h002);
    do_idle(2, 1, 0, 0, 9'h004);
    do_idle(2, 1, 0, 32'hCAFEF00D, 9'h008);
    do_idle(2, 0, 0, 0, 0);
    // Reset mid-stream: in-flight responses dropped, register cleared.
    do_rd(2, 32'h0C, 9'h001, 1, 0, 0, 0, 0);
    do_rd(2, 32'h00, 9'h002, 1, 0, 0, 0, 0);
    rst_n = 1'b0;
    do_rd(2, 32'h0C, 9'h003, 0, 0, 0, 0, 0);
    do_rd(2, 32'h0C, 9'h003, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    do_rd(2, 32'h0C, 9'h004, 1, 0, 0, 0, 0);
    do_idle(2, 0, 0, 0, 0);
    do_idle(2, 0, 0, 0, 0);
    do_idle(2, 0, 0, 0, 0);
    do_idle(2, 1, 0, 0, 9'h004);
    do_idle(2, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/periph_reg_target.md
PERIPH_REG_TARGET -- requirements
Module: periph_reg_target

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; BE_WIDTH fixed at DATA_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 9, transaction id width (one-hot initiator id).
REQ-004 SHALL have parameter NB_REGS, default 8, register count, power of two, 2..256.
REQ-005 SHALL have parameter WAIT_CYCLES, default 0, grant wait states per request, 0..15.
REQ-006 SHALL have parameter RESP_LATENCY, default 1, cycles from grant to r_valid, 1..4.
REQ-007 SHALL have parameter ID_VALUE, default 32'hCA1B_0001, constant value of register 0.
REQ-008 SHALL have clk_i, input, 1, the single clock.
REQ-009 SHALL have rst_ni, input, 1, reset, synchronous and active-low.
REQ-010 SHALL have req_i, input, 1, request valid.
REQ-011 SHALL have add_i, input, ADDR_WIDTH, byte address.
REQ-012 SHALL have wen_i, input, 1, active-low write enable: 0 = write, 1 = read.
REQ-013 SHALL have wdata_i, input, DATA_WIDTH, write data.
REQ-014 SHALL have be_i, input, BE_WIDTH, byte enables.
REQ-015 SHALL have id_i, input, ID_WIDTH, initiator id.
REQ-016 SHALL have gnt_o, output, 1, request accepted this cycle.
REQ-017 SHALL have r_valid_o, output, 1, response valid, single-cycle pulse per transaction.
REQ-018 SHALL have r_rdata_o, output, DATA_WIDTH, read data.
REQ-019 SHALL have r_opc_o, output, 1, 0 = OK, 1 = error.
REQ-020 SHALL have r_id_o, output, ID_WIDTH, echoed id of the transaction.

Function
REQ-021 SHALL accept a transaction on any rising edge with req_i & gnt_o both high; no response-side backpressure exists.
REQ-022 SHALL decode index = add_i[9:2]; error if add_i[1:0] != 0, index >= NB_REGS, or a write targets index 0.
REQ-023 SHALL, on an accepted non-error write, update register[index] byte b from wdata_i only where be_i[b]=1, effective at the accepting edge.
REQ-024 SHALL, on an accepted non-error read, capture register[index] as it is in the accepting cycle (before any write at that edge); register 0 reads ID_VALUE.
REQ-025 SHALL return r_rdata_o = 0 for writes and for errors; an error transaction SHALL have no side effect on state.
REQ-026 SHALL use an FSM with states IDLE and WAIT plus a 4-bit wait counter.
REQ-027 With WAIT_CYCLES=0 SHALL drive gnt_o = req_i combinationally in IDLE; throughput is one transaction per cycle and the FSM never leaves IDLE.
REQ-028 With WAIT_CYCLES>0: in IDLE, req_i=1 SHALL move to WAIT with counter = WAIT_CYCLES-1 and gnt_o=0.
REQ-029 In WAIT, counter>0 SHALL decrement with gnt_o=0; counter=0 SHALL assert gnt_o=req_i and return to IDLE.
REQ-030 A request first seen in cycle k SHALL be granted in cycle k+WAIT_CYCLES; the next request SHALL restart from IDLE.
REQ-031 If req_i drops while in WAIT, the FSM SHALL return to IDLE next cycle with no grant and no side effect.
REQ-032 SHALL raise r_valid_o exactly RESP_LATENCY cycles after the accepting edge, carrying that transaction's id, opc and rdata; responses SHALL be delivered in order.
REQ-033 SHALL implement the response path as a RESP_LATENCY-deep shift pipeline that holds up to RESP_LATENCY in-flight responses, so back-to-back grants never stall.
REQ-034 SHALL hold r_rdata_o, r_opc_o and r_id_o at 0 whenever r_valid_o=0.
REQ-035 A read issued the cycle after a write to the same register SHALL return the newly written value.

Reset
REQ-036 While rst_ni=0 at a clock edge: FSM->IDLE, counter->0, registers 1..NB_REGS-1 -> 0, response pipeline cleared.
REQ-037 gnt_o SHALL be 0 while rst_ni=0; in-flight responses at reset SHALL be dropped and never appear.

Verification
REQ-038 W=0,L=1: write 0xDEADBEEF, be=4'hF, to 0x08 with id=0x004; read 0x08 next cycle -> writes granted same cycle; responses {opc0, rdata0, id 0x004} then {opc0, 0xDEADBEEF}, each one cycle after grant.
REQ-039 Byte enables: reg1=0x11223344, write 0xAABBCCDD be=4'b0101 to 0x04 -> read returns 0x11BB33DD.
REQ-040 Errors: read 0x20 (NB_REGS=8), read 0x05, write 0x00 -> each r_opc=1, rdata=0; read 0x00 returns ID_VALUE.
REQ-041 W=3, L=4: request held from cycle 10 -> gnt in cycle 13 only; r_valid in cycle 17; req dropped in cycle 11 of a retry -> no grant, FSM IDLE.
REQ-042 L=4, four back-to-back reads, ids 0x001,0x002,0x004,0x008 -> four consecutive r_valid pulses in order; assert rst_ni=0 mid-stream -> no further r_valid, registers cleared.
